puf_challenge_sequencer: RTL and testbench

Drives the arbiter PUF macro from the user clock domain. It expands a 16-bit seed into a sequence of LFSR challenges and fires the PUF race pulse for each challenge. It synchronises and majority-votes the PUF response and assembles a RESP_W-bit response word. It sits directly upstream of `arbiterpuf`, feeding `ichallenge`/`ipulse` and consuming `oresponse`.

---
 rtl/puf_pkg.sv | 20 ++
 rtl/puf_challenge_sequencer_if.sv | 29 ++
 rtl/puf_resp_sync.sv | 22 ++
 rtl/puf_challenge_sequencer.sv | 131 +++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared types and LFSR helpers for the arbiter-PUF challenge sequencer.
// Pure declarations: no latency or flow control of its own.
package puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Feedback taps for x^16+x^14+x^13+x^11+1 in Fibonacci form: bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;

  function automatic logic [15:0] lfsr_step(input logic [15:0] c);
    return {c[14:0], ^(c & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Control and PUF-side signals of the challenge sequencer; master = user/PUF side, slave = sequencer.
// Plain wires: no latency, start_i is a level request with no backpressure beyond busy_o.
interface puf_challenge_sequencer_if #(
  parameter int CHAL_W = 16,
  parameter int RESP_W = 32
);
  localparam int CNT_W = $clog2(RESP_W + 1);

  logic              start_i;
  logic [CHAL_W-1:0] seed_i;
  logic              busy_o;
  logic              done_o;
  logic [RESP_W-1:0] response_o;
  logic [CNT_W-1:0]  unstable_cnt_o;
  logic [CHAL_W-1:0] ichallenge;
  logic              ipulse;
  logic              oresponse;

  modport master (
    output start_i, seed_i, oresponse,
    input  busy_o, done_o, response_o, unstable_cnt_o, ichallenge, ipulse
  );

  modport slave (
    input  start_i, seed_i, oresponse,
    output busy_o, done_o, response_o, unstable_cnt_o, ichallenge, ipulse
  );

endinterface

// File: rtl/puf_resp_sync.sv
// Two-flop synchroniser bringing the asynchronous arbiter output into the clock domain.
// Latency two edges; no flow control.
module puf_resp_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_o <= meta_q;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Expands a seed into LFSR challenges, races the PUF VOTES times per bit and majority-votes a response word.
// done_o after 1+RESP_W*VOTES*(SETTLE+HOLD) cycles; start_i is dropped (not queued) while busy.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int CHAL_W = 16,
  parameter int RESP_W = 32,
  parameter int VOTES  = 7,
  parameter int SETTLE = 4,
  parameter int HOLD   = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  puf_challenge_sequencer_if.slave sif
);

  localparam int CNT_W   = $clog2(RESP_W + 1);
  localparam int ONES_W  = $clog2(VOTES + 1);
  localparam int PH_MAX  = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int PH_W    = $clog2(PH_MAX);
  localparam int TRIAL_W = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int BIT_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;

  localparam logic [PH_W-1:0]    SETTLE_LAST = PH_W'(SETTLE - 1);
  localparam logic [PH_W-1:0]    HOLD_LAST   = PH_W'(HOLD - 1);
  localparam logic [TRIAL_W-1:0] TRIAL_LAST  = TRIAL_W'(VOTES - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST    = BIT_W'(RESP_W - 1);
  localparam logic [ONES_W-1:0]  ONES_ALL    = ONES_W'(VOTES);
  localparam logic [ONES_W-1:0]  ONES_HALF   = ONES_W'(VOTES / 2);

  state_t             state_q, state_nxt;
  logic [CHAL_W-1:0]  chal_q;
  logic [RESP_W-1:0]  resp_q;
  logic [CNT_W-1:0]   unst_q;
  logic [PH_W-1:0]    ph_q;
  logic [TRIAL_W-1:0] trial_q;
  logic [BIT_W-1:0]   bit_q;
  logic [ONES_W-1:0]  ones_q;
  logic               resp_sync;

  puf_resp_sync u_sync (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .async_i (sif.oresponse),
    .sync_o  (resp_sync)
  );

  logic              high_end, last_trial, last_bit, voted, unanimous;
  logic [ONES_W-1:0] ones_nxt;

  assign high_end   = (state_q == ST_HIGH) && (ph_q == HOLD_LAST);
  assign last_trial = (trial_q == TRIAL_LAST);
  assign last_bit   = (bit_q == BIT_LAST);
  assign ones_nxt   = ones_q + ONES_W'(resp_sync);
  assign voted      = (ones_nxt > ONES_HALF);
  assign unanimous  = (ones_nxt == '0) || (ones_nxt == ONES_ALL);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (sif.start_i) state_nxt = ST_LOW;
      ST_LOW:  if (ph_q == SETTLE_LAST) state_nxt = ST_HIGH;
      ST_HIGH: if (high_end) state_nxt = (last_trial && last_bit) ? ST_DONE : ST_LOW;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sif.busy_o = (state_q != ST_IDLE);
    sif.done_o = (state_q == ST_DONE);
    sif.ipulse = (state_q == ST_HIGH);
  end

  assign sif.ichallenge     = chal_q;
  assign sif.response_o     = resp_q;
  assign sif.unstable_cnt_o = unst_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      chal_q  <= '0;
      resp_q  <= '0;
      unst_q  <= '0;
      ph_q    <= '0;
      trial_q <= '0;
      bit_q   <= '0;
      ones_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sif.start_i) begin
            chal_q  <= (sif.seed_i == '0) ? ZERO_SEED_SUB : sif.seed_i;
            resp_q  <= '0;
            unst_q  <= '0;
            ph_q    <= '0;
            trial_q <= '0;
            bit_q   <= '0;
            ones_q  <= '0;
          end
        end
        ST_LOW: ph_q <= (ph_q == SETTLE_LAST) ? '0 : ph_q + 1'b1;
        ST_HIGH: begin
          if (ph_q == HOLD_LAST) begin
            ph_q <= '0;
            if (last_trial) begin
              // Challenge only moves here, so it is stable for the whole HIGH phase.
              resp_q  <= {resp_q[RESP_W-2:0], voted};
              unst_q  <= unanimous ? unst_q : unst_q + 1'b1;
              ones_q  <= '0;
              trial_q <= '0;
              bit_q   <= bit_q + 1'b1;
              chal_q  <= lfsr_step(chal_q);
            end else begin
              ones_q  <= ones_nxt;
              trial_q <= trial_q + 1'b1;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: arithmetic cycle model of the sequencer plus a table-driven PUF model.
// Checks every cycle at negedge; literal pins anchor the model on known seeds and patterns.
`timescale 1ns/1ps
module tb_puf_challenge_sequencer;

  localparam int CHAL_W    = 16;
  localparam int RESP_W    = 32;
  localparam int VOTES     = 7;
  localparam int SETTLE    = 4;
  localparam int HOLD      = 4;
  localparam int TRIAL_CYC = SETTLE + HOLD;
  localparam int BIT_CYC   = VOTES * TRIAL_CYC;
  localparam int DONE_N    = 1 + RESP_W * BIT_CYC;

  localparam int M_CHAL = 0, M_ONE = 1, M_ZERO = 2, M_NOISY = 3, M_RAND = 4;
  localparam int K_NONE = 0, K_RUN = 1, K_ZERO = 2;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  always #5 wb_clk_i = ~wb_clk_i;

  puf_challenge_sequencer_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) sif ();

  puf_challenge_sequencer #(
    .CHAL_W(CHAL_W), .RESP_W(RESP_W), .VOTES(VOTES), .SETTLE(SETTLE), .HOLD(HOLD)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .sif      (sif.slave)
  );

  // Written by the driver only.
  int                run_id   = 0;
  int                run_kind = K_NONE;
  int                puf_mode = M_ZERO;
  logic [15:0]       chal_seq [0:RESP_W];
  logic              resp_tab [RESP_W][VOTES];
  logic [RESP_W-1:0] exp_resp;
  int                exp_unst;
  bit                pin_r_en, pin_c0_en, pin_c1_en;
  logic [RESP_W-1:0] pin_resp;
  int                pin_unst;
  logic [15:0]       pin_c0, pin_c1;

  // Written by the compare process only.
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cmp_id   = 0;
  int          n        = 0;
  logic        prev_pulse = 1'b0;
  logic [15:0] prev_chal  = '0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  always @(negedge wb_clk_i) begin
    int m, b, p;
    if (run_id != cmp_id) begin
      cmp_id = run_id;
      n = 0;
    end
    n++;
    if (run_kind == K_ZERO) begin
      chk("rst_ipulse", sif.ipulse, 0);
      chk("rst_busy", sif.busy_o, 0);
      chk("rst_done", sif.done_o, 0);
      chk("rst_chal", sif.ichallenge, 0);
      chk("rst_resp", sif.response_o, 0);
      chk("rst_unst", sif.unstable_cnt_o, 0);
    end else if (run_kind == K_RUN) begin
      if (n < DONE_N) begin
        m = n - 1;
        b = m / BIT_CYC;
        p = m % TRIAL_CYC;
        chk("busy", sif.busy_o, 1);
        chk("done", sif.done_o, 0);
        chk("ipulse", sif.ipulse, (p >= SETTLE) ? 1 : 0);
        chk("chal", sif.ichallenge, chal_seq[b]);
      end else begin
        chk("busy", sif.busy_o, (n == DONE_N) ? 1 : 0);
        chk("done", sif.done_o, (n == DONE_N) ? 1 : 0);
        chk("ipulse", sif.ipulse, 0);
        chk("chal_end", sif.ichallenge, chal_seq[RESP_W]);
        chk("resp", sif.response_o, exp_resp);
        chk("unst", sif.unstable_cnt_o, exp_unst);
        if (n == DONE_N && pin_r_en) begin
          chk("pin_resp", sif.response_o, pin_resp);
          chk("pin_unst", sif.unstable_cnt_o, pin_unst);
        end
      end
      if (sif.done_o === 1'b1) chk("done_cycle", n, 1793);
      if (n == 1 && pin_c0_en) chk("pin_first_chal", sif.ichallenge, pin_c0);
      if (n == BIT_CYC + 1 && pin_c1_en) chk("pin_second_chal", sif.ichallenge, pin_c1);
    end
    if (prev_pulse === 1'b1 && sif.ipulse === 1'b1) chk("chal_stable_high", sif.ichallenge, prev_chal);
    prev_pulse = sif.ipulse;
    prev_chal  = sif.ichallenge;
  end

  // PUF model: answers each race shortly after the pulse rises and holds the level.
  initial begin : puf_model
    int rise, seen, b, t;
    sif.oresponse = 1'b0;
    rise = 0;
    seen = -1;
    forever begin
      @(posedge sif.ipulse);
      if (seen != run_id) begin
        seen = run_id;
        rise = 0;
      end
      b = rise / VOTES;
      t = rise % VOTES;
      rise++;
      #1;
      if (b < RESP_W) sif.oresponse = (puf_mode == M_CHAL) ? sif.ichallenge[0] : resp_tab[b][t];
    end
  end

  task automatic do_run(input logic [15:0] seed, input int mode, input bit poke, input int abort_at,
                        input bit pr_en, input logic [RESP_W-1:0] pr, input int pu,
                        input bit c0_en, input logic [15:0] c0, input bit c1_en, input logic [15:0] c1);
    logic [15:0]       s;
    logic [RESP_W-1:0] r;
    int                ones, u, kind;
    @(negedge wb_clk_i);
    #1;
    s = (seed == 16'h0) ? 16'h0001 : seed;
    for (int b = 0; b <= RESP_W; b++) begin
      chal_seq[b] = s;
      s = lfsr_next(s);
    end
    for (int b = 0; b < RESP_W; b++) begin
      kind = $urandom_range(0, 3);
      for (int t = 0; t < VOTES; t++) begin
        case (mode)
          M_ONE:   resp_tab[b][t] = 1'b1;
          M_NOISY: resp_tab[b][t] = (b == 5 && t < 3) || (b == 9 && t < 4);
          M_RAND:  resp_tab[b][t] = (kind == 0) ? 1'b0 : (kind == 1) ? 1'b1 : 1'($urandom);
          default: resp_tab[b][t] = 1'b0;
        endcase
      end
    end
    r = '0;
    u = 0;
    for (int b = 0; b < RESP_W; b++) begin
      ones = 0;
      for (int t = 0; t < VOTES; t++)
        ones += (mode == M_CHAL) ? int'(chal_seq[b][0]) : int'(resp_tab[b][t]);
      r = {r[RESP_W-2:0], (ones > VOTES / 2) ? 1'b1 : 1'b0};
      if (ones != 0 && ones != VOTES) u++;
    end
    exp_resp = r;
    exp_unst = u;
    puf_mode = mode;
    pin_r_en = pr_en;  pin_resp = pr;  pin_unst = pu;
    pin_c0_en = c0_en; pin_c0 = c0;
    pin_c1_en = c1_en; pin_c1 = c1;
    sif.seed_i  = seed;
    sif.start_i = 1'b1;
    run_kind    = K_RUN;
    run_id++;
    @(posedge wb_clk_i);
    #1;
    sif.start_i = 1'b0;
    sif.seed_i  = 16'($urandom);
    for (int k = 1; k <= DONE_N + 6; k++) begin
      @(negedge wb_clk_i);
      if (poke && k == 100) begin
        #1;
        sif.start_i = 1'b1;
        sif.seed_i  = 16'h1234;
        @(posedge wb_clk_i);
        #1;
        sif.start_i = 1'b0;
      end
      if (abort_at != 0 && k == abort_at) begin
        #1;
        wb_rst_i = 1'b1;
        run_kind = K_ZERO;
        run_id++;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        repeat (30) @(negedge wb_clk_i);
        break;
      end
    end
  endtask

  initial begin
    wb_rst_i    = 1'b1;
    sif.start_i = 1'b0;
    sif.seed_i  = '0;
    @(negedge wb_clk_i);
    #1;
    run_kind = K_ZERO;
    run_id++;
    @(negedge wb_clk_i);
    #1;
    sif.start_i = 1'b1;
    sif.seed_i  = 16'hBEEF;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i    = 1'b0;
    sif.start_i = 1'b0;
    repeat (20) @(negedge wb_clk_i);

    do_run(16'hACE1, M_CHAL, 0, 0, 0, '0, 0, 1, 16'hACE1, 1, 16'h59C3);
    do_run(16'h5A5A, M_ONE, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, '0, 0, '0);
    do_run(16'h0F0F, M_ZERO, 0, 0, 1, 32'h0000_0000, 0, 0, '0, 0, '0);
    // Collection order: bit 9 is the tenth bit shifted in, so it lands at response_o[22].
    do_run(16'h1357, M_NOISY, 0, 0, 1, 32'h0040_0000, 2, 0, '0, 0, '0);
    do_run(16'h0000, M_RAND, 0, 0, 0, '0, 0, 1, 16'h0001, 0, '0);
    do_run(16'($urandom), M_CHAL, 1, 0, 0, '0, 0, 0, '0, 0, '0);
    do_run(16'($urandom), M_RAND, 1, 0, 0, '0, 0, 0, '0, 0, '0);
    do_run(16'($urandom), M_RAND, 0, 0, 0, '0, 0, 0, '0, 0, '0);
    do_run(16'hC0DE, M_RAND, 0, 500, 0, '0, 0, 0, '0, 0, '0);

    @(negedge wb_clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
